// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// funct3 encodings, byte-strobe bases and access legality helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_e;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Strobe patterns for lane 0; shifted by the byte offset for sub-word stores
    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    function automatic logic fun3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return f3 inside {LB, LH, LW, LBU, LHU, LWU};
        return f3 inside {SB, SH, SW};
    endfunction

    // funct3[1:0] carries the access size for every legal encoding
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// Data-memory bus between the LSU (master) and the memory system (slave).
interface lsu_controller_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// Purely combinational data alignment: store strobe/data replication and
// load lane selection with sign or zero extension.
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  i_fun3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;

    // Store side: replicate the source across the word so any lane can pick it up
    always_comb begin
        o_wstrb = STRB_W;
        o_wdata = i_wdata;
        case (i_fun3[1:0])
            2'b00: begin
                o_wstrb = STRB_B << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_wstrb = STRB_H << i_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend
    always_comb begin
        w_shift = i_rdata >> {i_off, 3'b000};
        case (i_fun3)
            LB:      o_rdata = {{24{w_shift[7]}},  w_shift[7:0]};
            LH:      o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            LBU:     o_rdata = {24'h0, w_shift[7:0]};
            LHU:     o_rdata = {16'h0, w_shift[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store unit controller: validates an execute-stage memory access,
// runs a single request/response on the data bus while stalling the pipe,
// and aborts with an error if the bus does not answer in time.
import lsu_pkg::*;

module lsu_controller #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [2:0]  fun3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        err_o,
    lsu_controller_if.master mem
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       r_state;
    lsu_state_e       w_next;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [2:0]       r_fun3;
    logic             r_we;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [31:0]      r_load_data;

    logic             w_access;
    logic             w_legal;
    logic             w_start;
    logic             w_capture;
    logic             w_err_set;
    logic             w_req;
    logic             w_stall;
    logic             w_timeout;
    logic [3:0]       w_wstrb;
    logic [31:0]      w_wdata_rep;
    logic [31:0]      w_ld_val;

    assign w_access  = load_i | store_i;
    assign w_legal   = (load_i ^ store_i) && fun3_legal(load_i, fun3_i)
                       && !misaligned(fun3_i, addr_i[1:0]);
    assign w_timeout = (r_cnt == CNT_LAST);

    // Alignment works from latched values so bus outputs stay stable while waiting for grant
    lsu_align u_align (
        .i_fun3  (r_fun3),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (mem.mem_rdata_i),
        .o_wstrb (w_wstrb),
        .o_wdata (w_wdata_rep),
        .o_rdata (w_ld_val)
    );

    // Next-state and control decode; a response beats a timeout in the same cycle
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_err_set = 1'b0;
        w_req     = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_legal) begin
                        w_start = 1'b1;
                        w_stall = 1'b1;
                        w_next  = REQ;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (mem.mem_gnt_i) begin
                    if (r_we) begin
                        w_next = DONE;
                    end else if (mem.mem_rvalid_i) begin
                        w_capture = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_next = WAIT_RSP;
                    end
                end else if (w_timeout) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end
            end
            WAIT_RSP: begin
                w_stall = 1'b1;
                if (mem.mem_rvalid_i) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end else if (w_timeout) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State, latched access, timeout counter, error pulse and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_fun3      <= '0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
            if (w_start) begin
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_fun3  <= fun3_i;
                r_we    <= store_i;
                r_cnt   <= '0;
            end else if (r_state == REQ || r_state == WAIT_RSP) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture)
                r_load_data <= w_ld_val;
        end
    end

    assign stall_o         = w_stall;
    assign load_valid_o    = (r_state == DONE) && !r_we;
    assign err_o           = r_err;
    assign load_data_o     = r_load_data;

    assign mem.mem_req_o   = w_req;
    assign mem.mem_we_o    = r_we;
    assign mem.mem_addr_o  = {r_addr[31:2], 2'b00};
    assign mem.mem_wdata_o = w_wdata_rep;
    assign mem.mem_wstrb_o = r_we ? w_wstrb : 4'b0000;

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed cases plus randomized
// accesses checked cycle by cycle against a behavioural access model.
module tb_lsu_controller;

    localparam int T = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_i, store_i;
    logic [2:0]  fun3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, load_valid_o, err_o;
    logic [31:0] load_data_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_load = 32'h0;

    lsu_controller_if u_if ();

    lsu_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_i),
        .store_i      (store_i),
        .fun3_i       (fun3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .err_o        (err_o),
        .mem          (u_if)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit ref_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (ld) ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        else    ok = f3 inside {3'b000, 3'b001, 3'b010};
        return ok && ((a % ref_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = ref_size(f3);
        return 4'((((1 << n) - 1) << (a % 4)) & 15);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (ref_size(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (ref_size(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'b000: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
            3'b001: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            3'b100: v = v & 32'hFF;
            3'b101: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    // ---------------- scenarios ----------------
    // Entry/exit at posedge+1. gdly: REQ cycles before grant; rdly: cycles from grant to rvalid.
    task automatic run_access(input string tag, input bit is_ld, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int gdly, input int rdly);
        int c_g, c_rv, c_done;
        bit e_stall, e_req, e_lv;
        c_g    = 1 + gdly;
        c_rv   = is_ld ? c_g + rdly : -1;
        c_done = is_ld ? c_rv + 1 : c_g + 1;
        load_i = is_ld; store_i = !is_ld; fun3_i = f3; addr_i = a; wdata_i = wd;
        for (int c = 0; c <= c_done; c++) begin
            u_if.mem_gnt_i    = (c == c_g);
            u_if.mem_rvalid_i = (c == c_rv) || (c == c_done);
            u_if.mem_rdata_i  = (c == c_rv) ? rd : ~rd;
            @(negedge clk);
            e_stall = (c < c_done);
            e_req   = (c >= 1 && c <= c_g);
            e_lv    = is_ld && (c == c_done);
            if (is_ld && c == c_done) exp_load = ref_load(f3, a, rd);
            checks++; if (stall_o !== e_stall) begin errors++;
                $display("FAIL %s stall c=%0d got=%b exp=%b", tag, c, stall_o, e_stall); end
            checks++; if (u_if.mem_req_o !== e_req) begin errors++;
                $display("FAIL %s mem_req c=%0d got=%b exp=%b", tag, c, u_if.mem_req_o, e_req); end
            checks++; if (load_valid_o !== e_lv) begin errors++;
                $display("FAIL %s load_valid c=%0d got=%b exp=%b", tag, c, load_valid_o, e_lv); end
            checks++; if (err_o !== 1'b0) begin errors++;
                $display("FAIL %s err c=%0d got=%b exp=0", tag, c, err_o); end
            checks++; if (load_data_o !== exp_load) begin errors++;
                $display("FAIL %s load_data c=%0d got=%h exp=%h", tag, c, load_data_o, exp_load); end
            if (e_req) begin
                checks++; if (u_if.mem_addr_o !== {a[31:2], 2'b00}) begin errors++;
                    $display("FAIL %s mem_addr c=%0d got=%h exp=%h", tag, c, u_if.mem_addr_o, {a[31:2], 2'b00}); end
                checks++; if (u_if.mem_we_o !== !is_ld) begin errors++;
                    $display("FAIL %s mem_we c=%0d got=%b exp=%b", tag, c, u_if.mem_we_o, !is_ld); end
                if (!is_ld) begin
                    checks++; if (u_if.mem_wstrb_o !== ref_strb(f3, a)) begin errors++;
                        $display("FAIL %s wstrb c=%0d got=%b exp=%b", tag, c, u_if.mem_wstrb_o, ref_strb(f3, a)); end
                    checks++; if (u_if.mem_wdata_o !== ref_wdata(f3, wd)) begin errors++;
                        $display("FAIL %s wdata c=%0d got=%h exp=%h", tag, c, u_if.mem_wdata_o, ref_wdata(f3, wd)); end
                end
            end
            @(posedge clk); #1;
        end
        load_i = 0; store_i = 0; u_if.mem_gnt_i = 0; u_if.mem_rvalid_i = 0;
    endtask

    task automatic run_err(input string tag, input bit ld, input bit st,
                           input logic [2:0] f3, input logic [31:0] a);
        load_i = ld; store_i = st; fun3_i = f3; addr_i = a; wdata_i = $urandom;
        u_if.mem_gnt_i = 1'b1; u_if.mem_rvalid_i = 1'b0;
        @(negedge clk);
        checks++; if (stall_o !== 1'b0 || u_if.mem_req_o !== 1'b0) begin errors++;
            $display("FAIL %s present stall/req got=%b%b exp=00", tag, stall_o, u_if.mem_req_o); end
        @(posedge clk); #1;
        load_i = 0; store_i = 0; u_if.mem_gnt_i = 0;
        @(negedge clk);
        checks++; if (err_o !== 1'b1) begin errors++;
            $display("FAIL %s err_pulse got=%b exp=1", tag, err_o); end
        checks++; if (stall_o !== 1'b0 || u_if.mem_req_o !== 1'b0 || load_valid_o !== 1'b0) begin errors++;
            $display("FAIL %s after stall/req/lv got=%b%b%b exp=000", tag, stall_o, u_if.mem_req_o, load_valid_o); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (err_o !== 1'b0 || u_if.mem_req_o !== 1'b0) begin errors++;
            $display("FAIL %s err_clear err/req got=%b%b exp=00", tag, err_o, u_if.mem_req_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; load_i = 0; store_i = 0; fun3_i = 0; addr_i = 0; wdata_i = 0;
        u_if.mem_gnt_i = 0; u_if.mem_rvalid_i = 0; u_if.mem_rdata_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({stall_o, load_valid_o, err_o, u_if.mem_req_o, u_if.mem_we_o} !== 5'b0) begin errors++;
            $display("FAIL reset ctrl got=%b exp=00000", {stall_o, load_valid_o, err_o, u_if.mem_req_o, u_if.mem_we_o}); end
        checks++; if (u_if.mem_wstrb_o !== 4'h0 || u_if.mem_addr_o !== 32'h0 || u_if.mem_wdata_o !== 32'h0) begin errors++;
            $display("FAIL reset bus got strb=%h addr=%h wdata=%h exp=0", u_if.mem_wstrb_o, u_if.mem_addr_o, u_if.mem_wdata_o); end
        checks++; if (load_data_o !== 32'h0) begin errors++;
            $display("FAIL reset load_data got=%h exp=0", load_data_o); end
        @(posedge clk); #1;
        rst_n = 1;
        exp_load = 32'h0;
    endtask

    task automatic test_directed();
        run_access("sw_100", 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_access("lb_203", 1, 3'b000, 32'h203, 32'h0, 32'h80FF_FF7F, 1, 1);
        checks++; if (load_data_o !== 32'hFFFF_FF80) begin errors++;
            $display("FAIL lb_203 value got=%h exp=ffffff80", load_data_o); end
        run_access("lbu_203", 1, 3'b100, 32'h203, 32'h0, 32'h80FF_FF7F, 1, 1);
        checks++; if (load_data_o !== 32'h0000_0080) begin errors++;
            $display("FAIL lbu_203 value got=%h exp=00000080", load_data_o); end
        run_access("sh_12", 0, 3'b001, 32'h12, 32'h0000_ABCD, 32'h0, 0, 0);
        run_access("lw_fast", 1, 3'b010, 32'h44, 32'h0, 32'h1234_5678, 0, 0);
        run_access("lh_2", 1, 3'b001, 32'h2, 32'h0, 32'h8001_7FFF, 2, 0);
        run_access("lhu_2", 1, 3'b101, 32'h6, 32'h0, 32'h8001_7FFF, 0, 2);
        run_access("sb_3", 0, 3'b000, 32'h7, 32'h0000_005A, 32'h0, 1, 0);
    endtask

    task automatic test_errors();
        run_err("lh_11", 1, 0, 3'b001, 32'h11);
        run_err("lw_02", 1, 0, 3'b010, 32'h02);
        run_err("lhu_03", 1, 0, 3'b101, 32'h03);
        run_err("ld_f011", 1, 0, 3'b011, 32'h00);
        run_err("ld_f111", 1, 0, 3'b111, 32'h00);
        run_err("st_f100", 0, 1, 3'b100, 32'h00);
        run_err("sw_01", 0, 1, 3'b010, 32'h01);
        run_err("ld_and_st", 1, 1, 3'b010, 32'h00);
    endtask

    task automatic test_random();
        bit ld;
        logic [2:0] f3;
        logic [31:0] a;
        logic [2:0] legal_ld [6];
        legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        for (int n = 0; n < 60; n++) begin
            ld = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) != 0)
                f3 = ld ? legal_ld[$urandom_range(0, 5)] : 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % ref_size(f3));
            if (ref_legal(ld, f3, a))
                run_access("rand", ld, f3, a, $urandom, $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 3));
            else
                run_err("rand_err", ld, !ld, f3, a);
        end
    endtask

    // Bus never answers: either no grant at all, or grant with no read data.
    task automatic test_timeout(input bit in_wait);
        int reqc, stallc;
        reqc = 0; stallc = 0;
        load_i = 1; store_i = 0; fun3_i = 3'b010; addr_i = 32'h40; wdata_i = 0;
        u_if.mem_rvalid_i = 0;
        for (int c = 0; c <= T; c++) begin
            u_if.mem_gnt_i = in_wait && (c == 1);
            @(negedge clk);
            reqc   += int'(u_if.mem_req_o);
            stallc += int'(stall_o);
            checks++; if (err_o !== 1'b0 || load_valid_o !== 1'b0) begin errors++;
                $display("FAIL timeout%0d early err/lv c=%0d got=%b%b exp=00", in_wait, c, err_o, load_valid_o); end
            @(posedge clk); #1;
        end
        load_i = 0; u_if.mem_gnt_i = 0;
        @(negedge clk);
        checks++; if (err_o !== 1'b1) begin errors++;
            $display("FAIL timeout%0d err got=%b exp=1", in_wait, err_o); end
        checks++; if (u_if.mem_req_o !== 1'b0 || stall_o !== 1'b0 || load_valid_o !== 1'b0) begin errors++;
            $display("FAIL timeout%0d release req/stall/lv got=%b%b%b exp=000", in_wait,
                     u_if.mem_req_o, stall_o, load_valid_o); end
        checks++; if (reqc !== (in_wait ? 1 : T)) begin errors++;
            $display("FAIL timeout%0d req_cycles got=%0d exp=%0d", in_wait, reqc, in_wait ? 1 : T); end
        checks++; if (stallc !== T + 1) begin errors++;
            $display("FAIL timeout%0d stall_cycles got=%0d exp=%0d", in_wait, stallc, T + 1); end
        @(posedge clk); #1;
        u_if.mem_rvalid_i = 1; u_if.mem_gnt_i = 1; u_if.mem_rdata_i = $urandom;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (load_valid_o !== 1'b0 || err_o !== 1'b0 || load_data_o !== exp_load) begin errors++;
                $display("FAIL timeout%0d late_rvalid lv=%b err=%b data=%h exp lv=0 err=0 data=%h",
                         in_wait, load_valid_o, err_o, load_data_o, exp_load); end
            @(posedge clk); #1;
        end
        u_if.mem_rvalid_i = 0; u_if.mem_gnt_i = 0;
    endtask

    task automatic test_reset_mid();
        load_i = 1; store_i = 0; fun3_i = 3'b010; addr_i = 32'h80; wdata_i = 0;
        u_if.mem_rvalid_i = 0;
        for (int c = 0; c < 4; c++) begin
            u_if.mem_gnt_i = (c == 1);
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst_n = 0; load_i = 0; u_if.mem_gnt_i = 0;
        @(negedge clk);
        checks++; if (stall_o !== 1'b1) begin errors++;
            $display("FAIL reset_mid in_wait stall got=%b exp=1", stall_o); end
        @(posedge clk); #1;
        rst_n = 1;
        exp_load = 32'h0;
        @(negedge clk);
        checks++; if ({stall_o, load_valid_o, err_o, u_if.mem_req_o, u_if.mem_we_o} !== 5'b0) begin errors++;
            $display("FAIL reset_mid ctrl got=%b exp=00000", {stall_o, load_valid_o, err_o, u_if.mem_req_o, u_if.mem_we_o}); end
        checks++; if (u_if.mem_addr_o !== 32'h0 || u_if.mem_wstrb_o !== 4'h0 || load_data_o !== 32'h0) begin errors++;
            $display("FAIL reset_mid bus addr=%h strb=%h data=%h exp=0", u_if.mem_addr_o, u_if.mem_wstrb_o, load_data_o); end
        @(posedge clk); #1;
        u_if.mem_rvalid_i = 1; u_if.mem_rdata_i = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (load_valid_o !== 1'b0 || err_o !== 1'b0 || load_data_o !== 32'h0) begin errors++;
                $display("FAIL reset_mid late_rvalid lv=%b err=%b data=%h exp lv=0 err=0 data=0",
                         load_valid_o, err_o, load_data_o); end
            @(posedge clk); #1;
        end
        u_if.mem_rvalid_i = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_random();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        run_access("post_reset", 1, 3'b000, 32'h1, 32'h0, 32'h0000_7F00, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
